neuron_config_tx: RTL and testbench
===================================

# neuron_config_tx

Serializing configuration transmitter for the neuron array: accepts one parallel configuration word plus a neuron address over a valid/ready handshake. It drives the per-neuron select, the shared CONTROL line and the serial SEQ line so that the addressed neuron's MEMORY-bit register is loaded MSB-first. It sits between the host-side register interface and the array's CONTROL/SEQ_IN/select inputs. It is the write-side counterpart of the neuron's serial SEQ_IN shift path.

## Interface
- NEURONS, 24, number of addressable neurons; valid addresses 0..NEURONS-1
- MEMORY, 8, configuration bits per neuron (shift length)
- ADDR_W, 7, width of neuron address
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_valid  input  1  request present
- cfg_ready  output  1  block can accept a request this cycle
- cfg_addr  input  ADDR_W  target neuron index
- cfg_data  input  MEMORY  configuration word, bit MEMORY-1 shifted first
- sel_addr  output  ADDR_W  neuron index currently being loaded
- sel_en  output  1  sel_addr valid; array enables only that neuron
- control  output  1  shift-mode enable to the neuron array
- seq_out  output  1  serial data to the selected neuron's SEQ_IN
- busy  output  1  transfer in progress (state != IDLE)
- done  output  1  one-cycle pulse: transfer complete
- err  output  1  one-cycle pulse: request with cfg_addr >= NEURONS rejected

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE: cfg_ready=1. A request is accepted on an edge where cfg_valid && cfg_ready.
  - In range: capture cfg_addr into sel_addr and cfg_data into the shift register; go to SETUP.
  - Out of range: assert err for the following cycle and stay in IDLE; outputs are unchanged.
- SETUP (1 cycle): sel_en=1, control=1, seq_out=0; load bit counter with MEMORY-1; go to SHIFT.
- SHIFT (MEMORY cycles): sel_en=1, control=1, seq_out = shift-register MSB; shift left by one each cycle; decrement the counter. Leave for HOLD when the counter is 0.
- HOLD (1 cycle): sel_en=1, control=0, seq_out=0, done=1; go to IDLE.
- Captured data and address are frozen for the whole transfer; changes on cfg_* while busy are ignored.
- cfg_ready=0 in every state except IDLE; there is no queuing.
- Counter width is $clog2(MEMORY). MEMORY=1 means a single SHIFT cycle.
- Reset (any time, including mid-SHIFT) forces:
  - state IDLE, cfg_ready=1;
  - sel_addr=0, sel_en=0, control=0, seq_out=0, busy=0, done=0, err=0, shift register 0.
  - A transfer interrupted by reset produces no done; the neuron register is left partially loaded, and re-sending the word is the host's job.
- All outputs are registered; none are combinational from cfg_* inputs, except cfg_ready, which is decoded from state only.

## Timing
- Accept edge = E0.
  - Cycle after E0: SETUP.
  - Next MEMORY cycles: SHIFT, carrying data bits MEMORY-1..0 in order.
  - Then one HOLD cycle with done=1.
  - cfg_ready returns high the cycle after HOLD.
- Transfer occupancy: MEMORY+2 cycles busy. Back-to-back throughput: one word per MEMORY+3 cycles.
- The neuron samples seq_out on the rising edge at the end of each SHIFT cycle, while control=1.
- err: high exactly the one cycle after the rejecting accept edge. A new request may be accepted on that same cycle.
- done and err never assert together.

## Structure
- Shared package neuron_cfg_pkg:
  - state enum {IDLE, SETUP, SHIFT, HOLD};
  - default NEURONS/MEMORY/ADDR_W constants, reused by the array top.
- Sub-module cfg_piso holds the MEMORY-bit parallel-in/serial-out register: load, shift-enable, MSB out, async clear.
- The FSM, bit counter and address check live in neuron_config_tx.

## Test plan
- Reset release, no requests -> cfg_ready=1, all other outputs 0 indefinitely.
- cfg_addr=5, cfg_data=8'hA5 (MEMORY=8):
  - SETUP 1 cycle with control=1, sel_addr=5;
  - seq_out over 8 cycles 1,0,1,0,0,1,0,1;
  - done pulse on cycle 10 after accept; cfg_ready high on cycle 11.
- cfg_addr=24 (NEURONS=24) -> err=1 for one cycle, busy/control/sel_en stay 0, cfg_ready stays 1.
- cfg_valid held high with words 8'hFF then 8'h00 -> second accept exactly 11 cycles after first; cfg_data changes mid-transfer do not affect seq_out.
- rst_n low during the 4th SHIFT cycle -> all outputs 0 asynchronously, no done; a fresh request after release completes normally.
- MEMORY=1 instance, cfg_data=1 -> SETUP, one SHIFT cycle seq_out=1, HOLD with done; 3 busy cycles.

Source files
------------

// File: rtl/neuron_cfg_pkg.sv
// Shared definitions for the neuron configuration path: transmitter FSM
// states and the default array geometry reused by the array top.
package neuron_cfg_pkg;

  localparam int CFG_NEURONS = 24;
  localparam int CFG_MEMORY  = 8;
  localparam int CFG_ADDR_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } cfg_state_e;

  // Bit-counter width; a one-bit register still exists when MEMORY is 1.
  function automatic int cnt_width(input int memory);
    return (memory > 1) ? $clog2(memory) : 1;
  endfunction

endpackage

// File: rtl/neuron_config_tx_if.sv
// Host-side request channel: one address/word pair over valid/ready.
interface neuron_config_tx_if #(
  parameter int ADDR_W = 7,
  parameter int MEMORY = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [MEMORY-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_addr, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/cfg_piso.sv
// Parallel-in / serial-out register holding the word being shifted into
// the selected neuron. MSB leaves first; zeros fill from the bottom.
module cfg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_q, data_d;

  // Load has priority; shifting uses << so a one-bit register also works.
  always_comb begin
    data_d = data_q;
    if (load)          data_d = din;
    else if (shift_en) data_d = data_q << 1;
  end

  // Word register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/neuron_config_tx.sv
// Serializing configuration transmitter: captures one word + neuron
// address, then drives select/CONTROL/SEQ so the neuron loads it MSB-first.
// Sequence per transfer: SETUP (1) -> SHIFT (MEMORY) -> HOLD (1, done).
module neuron_config_tx
  import neuron_cfg_pkg::*;
#(
  parameter int NEURONS = CFG_NEURONS,
  parameter int MEMORY  = CFG_MEMORY,
  parameter int ADDR_W  = CFG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  neuron_config_tx_if.slave cfg,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_en,
  output logic              control,
  output logic              seq_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W    = cnt_width(MEMORY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEMORY - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NEURONS);

  cfg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sel_addr_q, sel_addr_d;
  logic              sel_en_q, sel_en_d;
  logic              control_q, control_d;
  logic              seq_out_q, seq_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept, in_range;
  logic piso_load, piso_shift, piso_msb;

  cfg_piso #(.WIDTH(MEMORY)) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (piso_load),
    .shift_en (piso_shift),
    .din      (cfg.cfg_data),
    .msb      (piso_msb)
  );

  // Ready is a pure state decode so the host never sees a path from cfg_*.
  assign cfg.cfg_ready = (state_q == IDLE);

  // Next state, bit counter, address capture and the registered outputs.
  // Outputs are computed from state_d so each flop shows the state it is in.
  always_comb begin
    accept     = (state_q == IDLE) && cfg.cfg_valid;
    in_range   = {1'b0, cfg.cfg_addr} < ADDR_LIM;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_addr_d = sel_addr_q;
    err_d      = 1'b0;
    piso_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_range) begin
            state_d    = SETUP;
            sel_addr_d = cfg.cfg_addr;
            piso_load  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = SHIFT;
        cnt_d   = CNT_LOAD;
      end
      SHIFT: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The MSB is sampled into seq_out on the same edge the register shifts,
    // so each SHIFT cycle carries the next bit down.
    piso_shift = (state_d == SHIFT);
    seq_out_d  = piso_shift & piso_msb;
    sel_en_d   = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
    control_d  = (state_d == SETUP) || (state_d == SHIFT);
    done_d     = (state_d == HOLD);
  end

  // State and output registers; reset abandons any transfer without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_addr_q <= '0;
      sel_en_q   <= 1'b0;
      control_q  <= 1'b0;
      seq_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_addr_q <= sel_addr_d;
      sel_en_q   <= sel_en_d;
      control_q  <= control_d;
      seq_out_q  <= seq_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sel_addr = sel_addr_q;
  assign sel_en   = sel_en_q;
  assign control  = control_q;
  assign seq_out  = seq_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_neuron_config_tx.sv
// Directed bench for neuron_config_tx: cycle table for the main transfer,
// out-of-range and ignored-input cases, plus hand-written multi-cycle cases.
module tb_neuron_config_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance, MEMORY=8
  neuron_config_tx_if #(.ADDR_W(7), .MEMORY(8)) ifc ();
  logic [6:0] sel_addr;
  logic       sel_en, control, seq_out, busy, done, err;

  neuron_config_tx #(.NEURONS(24), .MEMORY(8), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(ifc.slave),
    .sel_addr(sel_addr), .sel_en(sel_en), .control(control),
    .seq_out(seq_out), .busy(busy), .done(done), .err(err)
  );

  // Single-bit instance, MEMORY=1
  neuron_config_tx_if #(.ADDR_W(7), .MEMORY(1)) ifc1 ();
  logic [6:0] sel_addr1;
  logic       sel_en1, control1, seq_out1, busy1, done1, err1;

  neuron_config_tx #(.NEURONS(24), .MEMORY(1), .ADDR_W(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg(ifc1.slave),
    .sel_addr(sel_addr1), .sel_en(sel_en1), .control(control1),
    .seq_out(seq_out1), .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct {
    logic       v;
    logic [6:0] a;
    logic [7:0] d;
    logic       rdy, en, ctl, seq, bsy, dn, er;
    logic [6:0] sel;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic v, input logic [6:0] a, input logic [7:0] d,
                              input logic rdy, input logic en, input logic ctl,
                              input logic seq, input logic bsy, input logic dn,
                              input logic er, input logic [6:0] sel);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.rdy = rdy; t.en = en; t.ctl = ctl;
    t.seq = seq; t.bsy = bsy; t.dn = dn; t.er = er; t.sel = sel;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"},  ifc.cfg_ready, 1);
    chk({nm, "_outs"},   {sel_addr, sel_en, control, seq_out, busy, done, err}, 0);
  endtask

  // Full transfer on the main instance with per-cycle checks.
  task automatic run_xfer(input logic [6:0] a, input logic [7:0] d, input string nm);
    ifc.cfg_valid = 1'b1; ifc.cfg_addr = a; ifc.cfg_data = d;
    step();
    ifc.cfg_valid = 1'b0; ifc.cfg_data = ~d;
    chk({nm, "_setup"}, {control, sel_en, seq_out, busy, sel_addr}, {4'b1101, a});
    for (int k = 7; k >= 0; k--) begin
      step();
      chk($sformatf("%s_bit%0d", nm, k), {control, seq_out}, {1'b1, d[k]});
    end
    step();
    chk({nm, "_hold"}, {done, control, sel_en, busy}, 4'b1011);
    step();
    chk({nm, "_end"}, {ifc.cfg_ready, done, busy}, 3'b100);
  endtask

  initial begin
    int a1, a2, ones1, ones2, ndone, nbusy;
    logic seqs[0:31];

    //            v  addr  data   rdy en ctl seq bsy dn er sel
    tbl[0]  = mk(1, 7'd5,  8'hA5, 0, 1, 1, 0, 1, 0, 0, 7'd5);
    tbl[1]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 1, 1, 0, 0, 7'd5);
    tbl[2]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 0, 1, 0, 0, 7'd5);
    tbl[3]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 1, 1, 0, 0, 7'd5);
    tbl[4]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 0, 1, 0, 0, 7'd5);
    tbl[5]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 0, 1, 0, 0, 7'd5);
    tbl[6]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 1, 1, 0, 0, 7'd5);
    tbl[7]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 0, 1, 0, 0, 7'd5);
    tbl[8]  = mk(0, 7'd0,  8'h00, 0, 1, 1, 1, 1, 0, 0, 7'd5);
    tbl[9]  = mk(0, 7'd0,  8'h00, 0, 1, 0, 0, 1, 1, 0, 7'd5);
    tbl[10] = mk(0, 7'd0,  8'h00, 1, 0, 0, 0, 0, 0, 0, 7'd5);
    tbl[11] = mk(1, 7'd24, 8'h3C, 1, 0, 0, 0, 0, 0, 1, 7'd5);
    tbl[12] = mk(0, 7'd0,  8'h00, 1, 0, 0, 0, 0, 0, 0, 7'd5);
    tbl[13] = mk(1, 7'd23, 8'h80, 0, 1, 1, 0, 1, 0, 0, 7'd23);
    tbl[14] = mk(1, 7'd3,  8'hFF, 0, 1, 1, 1, 1, 0, 0, 7'd23);
    for (int i = 15; i <= 21; i++)
      tbl[i] = mk(1, 7'd3, 8'hFF, 0, 1, 1, 0, 1, 0, 0, 7'd23);
    tbl[22] = mk(1, 7'd3,  8'hFF, 0, 1, 0, 0, 1, 1, 0, 7'd23);
    tbl[23] = mk(1, 7'd3,  8'hFF, 1, 0, 0, 0, 0, 0, 0, 7'd23);

    ifc.cfg_valid = 1'b0; ifc.cfg_addr = '0; ifc.cfg_data = '0;
    ifc1.cfg_valid = 1'b0; ifc1.cfg_addr = '0; ifc1.cfg_data = '0;

    // Reset, then idle with no requests
    repeat (3) step();
    chk_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // Cycle table
    for (int i = 0; i < 24; i++) begin
      ifc.cfg_valid = tbl[i].v; ifc.cfg_addr = tbl[i].a; ifc.cfg_data = tbl[i].d;
      step();
      chk($sformatf("v%0d_ready", i), ifc.cfg_ready, tbl[i].rdy);
      chk($sformatf("v%0d_sel_en", i), sel_en, tbl[i].en);
      chk($sformatf("v%0d_control", i), control, tbl[i].ctl);
      chk($sformatf("v%0d_seq_out", i), seq_out, tbl[i].seq);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d_done", i), done, tbl[i].dn);
      chk($sformatf("v%0d_err", i), err, tbl[i].er);
      chk($sformatf("v%0d_sel_addr", i), sel_addr, tbl[i].sel);
    end
    ifc.cfg_valid = 1'b0;

    // Back-to-back with valid held: FF then 00, data switched mid-transfer
    a1 = -1; a2 = -1; ndone = 0;
    begin
      logic prev_busy;
      prev_busy = busy;
      ifc.cfg_valid = 1'b1; ifc.cfg_addr = 7'd2; ifc.cfg_data = 8'hFF;
      for (int c = 1; c < 32; c++) begin
        step();
        seqs[c] = seq_out;
        if (done) ndone++;
        if (busy && !prev_busy) begin
          if (a1 < 0) begin a1 = c; ifc.cfg_data = 8'h00; end
          else if (a2 < 0) begin a2 = c; ifc.cfg_valid = 1'b0; end
        end
        prev_busy = busy;
      end
      ifc.cfg_valid = 1'b0;
    end
    ones1 = 0; ones2 = 0;
    if (a1 > 0 && a1 + 8 < 32) for (int c = a1 + 1; c <= a1 + 8; c++) ones1 += int'(seqs[c]);
    if (a2 > 0 && a2 + 8 < 32) for (int c = a2 + 1; c <= a2 + 8; c++) ones2 += int'(seqs[c]);
    chk("b2b_spacing", a2 - a1, 11);
    chk("b2b_ones_ff", ones1, 8);
    chk("b2b_ones_00", ones2, 0);
    chk("b2b_done_count", ndone, 2);

    // Reset during the 4th SHIFT cycle
    ifc.cfg_valid = 1'b1; ifc.cfg_addr = 7'd7; ifc.cfg_data = 8'hF0;
    step();
    ifc.cfg_valid = 1'b0;
    repeat (4) step();
    chk("rst_pre_shift4", {control, seq_out, busy}, 3'b111);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    ndone = 0;
    repeat (3) begin
      step();
      if (done || busy) ndone++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      if (done || busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk_idle("rst_after");
    run_xfer(7'd9, 8'h81, "post_rst");
    run_xfer(7'd0, 8'h3C, "addr0");

    // MEMORY=1 instance
    nbusy = 0;
    ifc1.cfg_valid = 1'b1; ifc1.cfg_addr = 7'd4; ifc1.cfg_data = 1'b1;
    step();
    ifc1.cfg_valid = 1'b0;
    nbusy += int'(busy1);
    chk("m1_setup", {control1, sel_en1, seq_out1, done1, sel_addr1}, {4'b1100, 7'd4});
    step();
    nbusy += int'(busy1);
    chk("m1_shift", {control1, seq_out1, done1}, 3'b110);
    step();
    nbusy += int'(busy1);
    chk("m1_hold", {control1, seq_out1, done1, sel_en1}, 4'b0011);
    step();
    nbusy += int'(busy1);
    chk("m1_end", {ifc1.cfg_ready, busy1, done1}, 3'b100);
    chk("m1_busy_cycles", nbusy, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
